toggle_counter_bank: RTL and testbench



---
 rtl/toggle_counter_pkg.sv | 12 +
 rtl/toggle_counter_channel.sv | 70 +++++++
 rtl/toggle_counter_bank.sv | 47 ++++
 tb/tb_toggle_counter_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_counter_pkg.sv
// Shared constants and helpers for the toggle/divider channel bank.
package toggle_counter_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Width of a channel index; a single-channel bank still carries one index bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_counter_channel.sv
// One toggle/divider channel: period counter, output mode, and the
// clr > pre > config write > count priority chain.
module toggle_counter_channel
  import toggle_counter_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_mode,
  input  logic             i_en,
  input  logic             i_pre,
  input  logic             i_clr,
  output logic             o_q,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_q;
  logic             r_tick;
  logic             w_event;

  // cnt never passes period, so equality is the only terminal condition.
  assign w_event = i_en && (r_cnt == r_period);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_mode   <= MODE_TOGGLE;
      r_q      <= INIT_BIT;
      r_tick   <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_q    <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_pre) begin
      r_cnt  <= '0;
      r_q    <= 1'b1;
      r_tick <= 1'b0;
    end else if (i_we) begin
      r_period <= i_period;
      r_mode   <= i_mode;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      if (i_mode == MODE_PULSE) begin
        r_q <= 1'b0;
      end
    end else begin
      r_tick <= w_event;
      if (i_en) begin
        r_cnt <= w_event ? '0 : r_cnt + WIDTH'(1);
      end
      if (r_mode == MODE_PULSE) begin
        r_q <= w_event;
      end else if (w_event) begin
        r_q <= ~r_q;
      end
    end
  end

  assign o_q    = r_q;
  assign o_tick = r_tick;

endmodule

// File: rtl/toggle_counter_bank.sv
// Bank of independent toggle/divider channels sharing one clock and one
// configuration write port; out-of-range channel indices select nothing.
module toggle_counter_bank
  import toggle_counter_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  WIDTH    = 8,
  parameter logic [CHANNELS-1:0] INIT     = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [ch_idx_w(CHANNELS)-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]                  cfg_period,
  input  logic                              cfg_mode,
  input  logic [CHANNELS-1:0]               en,
  input  logic [CHANNELS-1:0]               pre,
  input  logic [CHANNELS-1:0]               clr,
  output logic [CHANNELS-1:0]               q,
  output logic [CHANNELS-1:0]               tick
);

  localparam int CH_W = ch_idx_w(CHANNELS);

  logic [CHANNELS-1:0] w_we;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

    toggle_counter_channel #(
      .WIDTH    (WIDTH),
      .INIT_BIT (INIT[g])
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_we[g]),
      .i_period (cfg_period),
      .i_mode   (cfg_mode),
      .i_en     (en[g]),
      .i_pre    (pre[g]),
      .i_clr    (clr[g]),
      .o_q      (q[g]),
      .o_tick   (tick[g])
    );
  end

endmodule

// File: tb/tb_toggle_counter_bank.sv
// Bench for toggle_counter_bank: a 4-channel bank and a 3-channel bank share
// stimulus so the 3-channel one sees index 3 as out of range.
module tb_toggle_counter_bank;

  localparam logic [3:0] INIT_A = 4'b0101;
  localparam logic [2:0] INIT_B = 3'b110;

  // clock/reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_mode = 1'b0;
  logic [3:0] en = '0;
  logic [3:0] pre = '0;
  logic [3:0] clr = '0;
  logic [3:0] qa, ta;
  logic [2:0] qb, tb;

  toggle_counter_bank #(.CHANNELS(4), .WIDTH(8), .INIT(INIT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .en(en), .pre(pre), .clr(clr), .q(qa), .tick(ta)
  );

  toggle_counter_bank #(.CHANNELS(3), .WIDTH(8), .INIT(INIT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .en(en[2:0]), .pre(pre[2:0]), .clr(clr[2:0]), .q(qb), .tick(tb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each channel tracks how many enabled cycles have passed
  // since its last restart; an event falls on every (P+1)-th one.
  int m_n   [2][4];
  int m_per [2][4];
  bit m_mode[2][4];
  bit m_q   [2][4];
  bit m_tick[2][4];

  task automatic model_step(input int d, input int nch, input logic [3:0] init);
    bit ev;
    for (int i = 0; i < nch; i++) begin
      if (!rst_n) begin
        m_n[d][i] = 0; m_per[d][i] = 0; m_mode[d][i] = 0;
        m_q[d][i] = init[i]; m_tick[d][i] = 0;
      end else if (clr[i]) begin
        m_n[d][i] = 0; m_q[d][i] = 0; m_tick[d][i] = 0;
      end else if (pre[i]) begin
        m_n[d][i] = 0; m_q[d][i] = 1; m_tick[d][i] = 0;
      end else if (cfg_we && int'(cfg_ch) == i) begin
        m_per[d][i] = int'(cfg_period); m_mode[d][i] = cfg_mode;
        m_n[d][i] = 0; m_tick[d][i] = 0;
        if (cfg_mode) m_q[d][i] = 0;
      end else begin
        ev = en[i] && ((m_n[d][i] % (m_per[d][i] + 1)) == m_per[d][i]);
        if (en[i]) m_n[d][i]++;
        m_tick[d][i] = ev;
        if (m_mode[d][i]) m_q[d][i] = ev;
        else if (ev) m_q[d][i] = !m_q[d][i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 4, INIT_A);
    model_step(1, 3, INIT_B);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_ch = '0; cfg_period = '0; cfg_mode = 0;
    en = '0; pre = '0; clr = '0; rst_n = 1;
  endtask

  // Table-driven vectors for the 4-channel bank.
  typedef struct {
    logic       rst_n;
    logic       we;
    logic [1:0] ch;
    logic [7:0] per;
    logic       mode;
    logic [3:0] en, pre, clr;
    logic [3:0] q, t;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t v(logic r, logic we, logic [1:0] ch, logic [7:0] per, logic mode,
                             logic [3:0] e, logic [3:0] p, logic [3:0] c,
                             logic [3:0] q, logic [3:0] t);
    vec_t x;
    x.rst_n = r; x.we = we; x.ch = ch; x.per = per; x.mode = mode;
    x.en = e; x.pre = p; x.clr = c; x.q = q; x.t = t;
    return x;
  endfunction

  logic [13:0] exp_q[$];

  initial begin
    logic [13:0] e;
    logic [3:0]  eqa, eta;
    logic [2:0]  eqb, etb;

    // reset defaults: P=0 toggle flips every enabled cycle
    tbl[0]  = v(0,0,0,0,0, 4'b0000,0,0, 4'b0101,4'b0000);
    tbl[1]  = v(0,0,0,0,0, 4'b0000,0,0, 4'b0101,4'b0000);
    tbl[2]  = v(1,0,0,0,0, 4'b1111,0,0, 4'b1010,4'b1111);
    tbl[3]  = v(1,0,0,0,0, 4'b1111,0,0, 4'b0101,4'b1111);
    tbl[4]  = v(1,0,0,0,0, 4'b0000,0,0, 4'b0101,4'b0000);
    // divider: ch1 P=3, events on the 4th and 8th enabled cycles
    tbl[5]  = v(1,1,1,3,0, 4'b0000,0,0, 4'b0101,4'b0000);
    tbl[6]  = v(1,0,0,0,0, 4'b0010,0,0, 4'b0101,4'b0000);
    tbl[7]  = v(1,0,0,0,0, 4'b0010,0,0, 4'b0101,4'b0000);
    tbl[8]  = v(1,0,0,0,0, 4'b0010,0,0, 4'b0101,4'b0000);
    tbl[9]  = v(1,0,0,0,0, 4'b0010,0,0, 4'b0111,4'b0010);
    tbl[10] = v(1,0,0,0,0, 4'b0010,0,0, 4'b0111,4'b0000);
    tbl[11] = v(1,0,0,0,0, 4'b0010,0,0, 4'b0111,4'b0000);
    tbl[12] = v(1,0,0,0,0, 4'b0010,0,0, 4'b0111,4'b0000);
    tbl[13] = v(1,0,0,0,0, 4'b0010,0,0, 4'b0101,4'b0010);
    // pulse mode with enable gaps: ch2 P=2, enables 1,1,0,0,1
    tbl[14] = v(1,1,2,2,1, 4'b0000,0,0, 4'b0001,4'b0000);
    tbl[15] = v(1,0,0,0,0, 4'b0100,0,0, 4'b0001,4'b0000);
    tbl[16] = v(1,0,0,0,0, 4'b0100,0,0, 4'b0001,4'b0000);
    tbl[17] = v(1,0,0,0,0, 4'b0000,0,0, 4'b0001,4'b0000);
    tbl[18] = v(1,0,0,0,0, 4'b0000,0,0, 4'b0001,4'b0000);
    tbl[19] = v(1,0,0,0,0, 4'b0100,0,0, 4'b0101,4'b0100);
    tbl[20] = v(1,0,0,0,0, 4'b0000,0,0, 4'b0001,4'b0000);
    // priority: clr beats pre beats write; ch0 keeps P=0 toggle
    tbl[21] = v(1,1,0,5,1, 4'b0000,4'b0001,4'b0001, 4'b0000,4'b0000);
    tbl[22] = v(1,0,0,0,0, 4'b0000,4'b0001,4'b0000, 4'b0001,4'b0000);
    tbl[23] = v(1,0,0,0,0, 4'b0001,0,0, 4'b0000,4'b0001);
    tbl[24] = v(1,0,0,0,0, 4'b0001,0,0, 4'b0001,4'b0001);
    // isolation: write ch0 while ch1 runs P=1
    tbl[25] = v(1,1,1,1,0, 4'b0000,0,0, 4'b0001,4'b0000);
    tbl[26] = v(1,0,0,0,0, 4'b0011,0,0, 4'b0000,4'b0001);
    tbl[27] = v(1,1,0,0,0, 4'b0011,0,0, 4'b0010,4'b0010);
    tbl[28] = v(1,0,0,0,0, 4'b0011,0,0, 4'b0011,4'b0001);
    tbl[29] = v(1,0,0,0,0, 4'b0011,0,0, 4'b0000,4'b0011);

    idle_inputs();
    rst_n = 0;
    for (int i = 0; i < 30; i++) begin
      rst_n = tbl[i].rst_n; cfg_we = tbl[i].we; cfg_ch = tbl[i].ch;
      cfg_period = tbl[i].per; cfg_mode = tbl[i].mode;
      en = tbl[i].en; pre = tbl[i].pre; clr = tbl[i].clr;
      step();
      check($sformatf("tbl_q[%0d]", i), 16'(qa), 16'(tbl[i].q));
      check($sformatf("tbl_tick[%0d]", i), 16'(ta), 16'(tbl[i].t));
    end

    // out-of-range write on the 3-channel bank changes nothing
    idle_inputs(); rst_n = 0; step();
    idle_inputs(); cfg_we = 1; cfg_ch = 2'd3; cfg_period = 8'd7; cfg_mode = 1; step();
    check("oor_q", 16'(qb), 16'(3'b110));
    check("oor_tick", 16'(tb), 16'(3'b000));
    idle_inputs(); en = 4'b0111; step();
    check("oor_after_q", 16'(qb), 16'(3'b001));
    check("oor_after_tick", 16'(tb), 16'(3'b111));

    // reset mid-count: ch3 P=200 stopped at cnt=150
    idle_inputs(); rst_n = 0; step();
    idle_inputs(); cfg_we = 1; cfg_ch = 2'd3; cfg_period = 8'd200; step();
    idle_inputs(); en = 4'b1000;
    for (int i = 0; i < 150; i++) step();
    check("mid_q", 16'(qa), 16'(4'b0101));
    check("mid_tick", 16'(ta), 16'(4'b0000));
    rst_n = 0; step();
    check("mid_rst_q", 16'(qa), 16'(4'b0101));
    check("mid_rst_tick", 16'(ta), 16'(4'b0000));
    rst_n = 1; step();
    check("resume1_q", 16'(qa), 16'(4'b1101));
    check("resume1_tick", 16'(ta), 16'(4'b1000));
    step();
    check("resume2_q", 16'(qa), 16'(4'b0101));
    check("resume2_tick", 16'(ta), 16'(4'b1000));

    // randomized run against the model, both banks
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      cfg_mode   = 1'($urandom_range(0, 1));
      en         = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      pre        = '0;
      clr        = '0;
      for (int i = 0; i < 4; i++) begin
        pre[i] = ($urandom_range(0, 15) == 0);
        clr[i] = ($urandom_range(0, 19) == 0);
      end
      step();
      eqa = '0; eta = '0; eqb = '0; etb = '0;
      for (int i = 0; i < 4; i++) begin
        eqa[i] = m_q[0][i]; eta[i] = m_tick[0][i];
      end
      for (int i = 0; i < 3; i++) begin
        eqb[i] = m_q[1][i]; etb[i] = m_tick[1][i];
      end
      exp_q.push_back({etb, eqb, eta, eqa});
      e = exp_q.pop_front();
      check($sformatf("rnd_a_q[%0d]", c), 16'(qa), 16'(e[3:0]));
      check($sformatf("rnd_a_tick[%0d]", c), 16'(ta), 16'(e[7:4]));
      check($sformatf("rnd_b_q[%0d]", c), 16'(qb), 16'(e[10:8]));
      check($sformatf("rnd_b_tick[%0d]", c), 16'(tb), 16'(e[13:11]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
